// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - geometry constants, FSM state type and address helpers for cache_controller
//
// Purpose: shared definitions for the 32 KiB, 4-way, 64-byte-line data cache.
// Ports:   none (package).
package cache_pkg;

  localparam int WAYS       = 4;
  localparam int SETS       = 128;
  localparam int TAG_W      = 19;
  localparam int IDX_W      = 7;
  localparam int LINE_W     = 512;
  localparam int WORD_SEL_W = 4;
  localparam int WAY_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    WB_DONE,
    ALLOCATE,
    RESPOND
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:13];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[12:6];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] a);
    return a[5:2];
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU load/store and block memory bus bundle for cache_controller
//
// Purpose: groups the CPU-side request/response and memory-side block
//          transfer signals.
// Modports:
//   slave  - the cache: takes CPU requests, drives memory requests.
//   master - the environment: drives CPU requests, answers memory requests.
// Signals: cpu_read, cpu_write, cpu_addr[31:0], cpu_write_data[31:0],
//          cpu_read_data[31:0], cpu_ready, mem_read, mem_write,
//          mem_addr[31:0], mem_write_data[511:0], mem_read_data[511:0], mem_ready.
interface cache_controller_if;
  import cache_pkg::*;

  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_write_data;
  logic [31:0]       cpu_read_data;
  logic              cpu_ready;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_write_data;
  logic [LINE_W-1:0] mem_read_data;
  logic              mem_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_write_data, mem_read_data, mem_ready,
    output cpu_read_data, cpu_ready, mem_read, mem_write, mem_addr, mem_write_data
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_write_data, mem_read_data, mem_ready,
    input  cpu_read_data, cpu_ready, mem_read, mem_write, mem_addr, mem_write_data
  );

endinterface

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set 2-bit age tracking and LRU way selection
//
// Purpose: holds a 2-bit age per way per set; reports the oldest way of the
//          selected set and updates ages when a way is accessed.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears all ages)
//   idx           - set being looked up / updated
//   upd_en        - access strobe for way upd_way in set idx
//   upd_way       - accessed way
//   lru_way       - oldest way of set idx (lowest index on a tie)
module cache_lru
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             upd_en,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] lru_way
);

  logic [1:0] age [SETS][WAYS];
  logic [1:0] old_age;
  logic [1:0] max_age;

  always_comb begin
    lru_way = '0;
    max_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[idx][w] > max_age) begin
        max_age = age[idx][w];
        lru_way = WAY_W'(w);
      end
    end
  end

  assign old_age = age[idx][upd_way];

  // Ages start all equal after reset, so ways tied with the accessed way's
  // old age also age; this spreads them into a distinct order as the set
  // fills. Once ages are distinct this is the plain "younger ways age" rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age[s][w] <= '0;
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w == int'(upd_way)) begin
          age[idx][w] <= '0;
        end else if (age[idx][w] <= old_age && age[idx][w] != 2'd3) begin
          age[idx][w] <= age[idx][w] + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 4-way write-back write-allocate data cache controller
//
// Purpose: serves single 32-bit CPU loads/stores from a 128-set x 4-way x
//          64-byte store; misses write back a dirty victim then refill.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - cache_controller_if.slave (CPU request/response, memory block bus)
//   hit_count, miss_count - 32-bit lookup counters, present only when
//                CACHE_PERF_CNT_EN is defined
module cache_controller
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cache_controller_if.slave   bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  state_t state;

  logic [LINE_W-1:0] data_mem  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic [31:0]           req_wdata;
  logic                  op_write;
  logic [WAY_W-1:0]      victim;

  logic              cpu_ready_q;
  logic [31:0]       cpu_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [31:0]       mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  miss_way;
  logic              lru_upd;
  logic [WAY_W-1:0]  lru_upd_way;
  logic [8:0]        word_off;
  logic [LINE_W-1:0] fill_line;

  wire unused_addr_bits = ^bus.cpu_addr[1:0];

  assign bus.cpu_ready      = cpu_ready_q;
  assign bus.cpu_read_data  = cpu_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;

  assign word_off = {req_word, 5'b0};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign miss_way = inv_found ? inv_way : lru_way;

  // Refill line with the pending store word already merged in.
  always_comb begin
    fill_line = bus.mem_read_data;
    if (op_write) begin
      fill_line[word_off +: 32] = req_wdata;
    end
  end

  assign lru_upd     = (state == LOOKUP && hit) || (state == ALLOCATE && bus.mem_ready);
  assign lru_upd_way = (state == LOOKUP) ? hit_way : victim;

  cache_lru u_lru (
    .clk     (clk),
    .rst     (rst),
    .idx     (req_idx),
    .upd_en  (lru_upd),
    .upd_way (lru_upd_way),
    .lru_way (lru_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
      end
      req_tag     <= '0;
      req_idx     <= '0;
      req_word    <= '0;
      req_wdata   <= '0;
      op_write    <= 1'b0;
      victim      <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_read || bus.cpu_write) begin
            req_tag   <= addr_tag(bus.cpu_addr);
            req_idx   <= addr_idx(bus.cpu_addr);
            req_word  <= addr_word(bus.cpu_addr);
            req_wdata <= bus.cpu_write_data;
            op_write  <= !bus.cpu_read;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (op_write) begin
              data_mem[req_idx][hit_way][word_off +: 32] <= req_wdata;
              dirty_mem[req_idx][hit_way] <= 1'b1;
            end else begin
              cpu_rdata_q <= data_mem[req_idx][hit_way][word_off +: 32];
            end
            cpu_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            victim <= miss_way;
            if (valid_mem[req_idx][miss_way] && dirty_mem[req_idx][miss_way]) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_mem[req_idx][miss_way], req_idx, 6'b0};
              mem_wdata_q <= data_mem[req_idx][miss_way];
              state       <= WRITEBACK;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, req_idx, 6'b0};
              state      <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            mem_write_q <= 1'b0;
            state       <= WB_DONE;
          end
        end
        WB_DONE: begin
          // Memory must drop ready before the refill request starts.
          if (!bus.mem_ready) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= {req_tag, req_idx, 6'b0};
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            mem_read_q                 <= 1'b0;
            data_mem[req_idx][victim]  <= fill_line;
            tag_mem[req_idx][victim]   <= req_tag;
            valid_mem[req_idx][victim] <= 1'b1;
            dirty_mem[req_idx][victim] <= op_write;
            if (!op_write) begin
              cpu_rdata_q <= fill_line[word_off +: 32];
            end
            cpu_ready_q <= 1'b1;
            state       <= RESPOND;
          end
        end
        RESPOND: begin
          if (!bus.mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Memory model: unwritten blocks hold each word's own byte address.
  logic [511:0] mem_store [int unsigned];

  function automatic logic [511:0] mem_get(input logic [31:0] a);
    logic [511:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int w = 0; w < 16; w++) l[32*w +: 32] = a + 32'(4 * w);
    return l;
  endfunction

  int n_rd = 0, n_wr = 0, ev = 0, rd_ev = 0, wr_ev = 0, viol = 0, lat_cnt = 0;
  logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [511:0] last_wr_data = '0;

  initial begin
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = 32'hA0 + 32'(w);
    mem_store[32'h0002_0040] = l;
    bus.mem_ready     = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(negedge clk);
      if ((bus.mem_read && bus.mem_write) ||
          (bus.cpu_ready && (bus.mem_read || bus.mem_write))) viol++;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (!rst && (bus.mem_read || bus.mem_write)) begin
        if (lat_cnt == 2) begin
          lat_cnt = 0;
          ev++;
          if (bus.mem_write) begin
            mem_store[bus.mem_addr] = bus.mem_write_data;
            n_wr++;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_write_data;
            wr_ev = ev;
          end else begin
            bus.mem_read_data = mem_get(bus.mem_addr);
            n_rd++;
            last_rd_addr = bus.mem_addr;
            rd_ev = ev;
          end
          bus.mem_ready = 1'b1;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  int passed = 0, failed = 0, total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  int          op_lat, d_rd, d_wr;
  logic        op_got;
  logic [31:0] op_data;

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int rd0, wr0;
    rd0 = n_rd;
    wr0 = n_wr;
    @(negedge clk);
    bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_addr = a; bus.cpu_write_data = d;
    @(negedge clk);
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    op_lat = 1;
    while (!bus.cpu_ready && op_lat < 200) begin
      @(negedge clk);
      op_lat++;
    end
    op_got  = bus.cpu_ready;
    op_data = bus.cpu_read_data;
    d_rd    = n_rd - rd0;
    d_wr    = n_wr - wr0;
    check("cpu_ready_seen", 32'(op_got), 32'd1);
  endtask

  initial begin
    logic [31:0] w0;
    rst = 1'b1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_cpu_read_data", bus.cpu_read_data, 32'd0);
    check("rst_mem_write_data", 32'(|bus.mem_write_data), 32'd0);
    rst = 1'b0;

    cpu_op(1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    check("w0_rd_count", d_rd, 1);
    check("w0_wr_count", d_wr, 0);
    check("w0_rd_addr", last_rd_addr, 32'h0);
    @(negedge clk);
    check("w0_ready_single", 32'(bus.cpu_ready), 32'd0);

    cpu_op(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check("r0_hit_lat", op_lat, 2);
    check("r0_hit_data", op_data, 32'hDEAD_BEEF);
    check("r0_no_traffic", d_rd + d_wr, 0);

    for (int t = 0; t < 4; t++) begin
      cpu_op(1'b0, 1'b1, 32'(t) << 13, 32'h1000 + 32'(t));
      check("fill_no_wb", d_wr, 0);
      check("fill_rd", d_rd, (t == 0) ? 0 : 1);
    end
    cpu_op(1'b0, 1'b1, 32'h0000_8000, 32'h1004);
    w0 = last_wr_data[31:0];
    check("t4_wr_count", d_wr, 1);
    check("t4_wr_addr", last_wr_addr, 32'h0);
    check("t4_wr_word0", w0, 32'h1000);
    check("t4_rd_addr", last_rd_addr, 32'h8000);
    check("t4_wb_before_rd", 32'(wr_ev < rd_ev), 32'd1);

    cpu_op(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    w0 = last_wr_data[31:0];
    check("r0b_wr_addr", last_wr_addr, 32'h2000);
    check("r0b_wr_word0", w0, 32'h1001);
    check("r0b_rd_addr", last_rd_addr, 32'h0);
    check("r0b_data", op_data, 32'h1000);

    cpu_op(1'b1, 1'b0, 32'h0002_0048, 32'h0);
    check("a2_data", op_data, 32'hA2);
    check("a2_no_wb", d_wr, 0);
    check("a2_rd_addr", last_rd_addr, 32'h0002_0040);
    cpu_op(1'b1, 1'b0, 32'h0002_0048, 32'h0);
    check("a2_rehit_lat", op_lat, 2);
    check("a2_rehit_data", op_data, 32'hA2);

    cpu_op(1'b1, 1'b1, 32'h0004_0080, 32'h5555_AAAA);
    check("both_data", op_data, 32'h0004_0080);
    check("both_rd", d_rd, 1);
    cpu_op(1'b1, 1'b0, 32'h0004_0080, 32'h0);
    check("both_nostore", op_data, 32'h0004_0080);
    check("both_rehit_lat", op_lat, 2);
    for (int k = 1; k <= 4; k++) begin
      cpu_op(1'b1, 1'b0, (32'(k) << 13) | 32'h80, 32'h0);
      check("set2_no_wb", d_wr, 0);
      check("set2_data", op_data, (32'(k) << 13) | 32'h80);
    end

`ifdef CACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'd4);
    check("miss_count", miss_count, 32'd12);
`endif

    @(negedge clk);
    bus.cpu_read = 1'b1; bus.cpu_addr = 32'h0000_00C0;
    @(negedge clk);
    bus.cpu_read = 1'b0;
    @(negedge clk);
    check("alloc_mem_read", 32'(bus.mem_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_alloc_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_alloc_mem_addr", bus.mem_addr, 32'd0);
    check("rst_alloc_ready", 32'(bus.cpu_ready), 32'd0);
    rst = 1'b0;

    cpu_op(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check("post_rst_miss", d_rd, 1);
    check("post_rst_no_wb", d_wr, 0);
    check("post_rst_data", op_data, 32'h1000);

    check("bus_exclusive", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
